// File: rtl/idct_ctrl_pkg.sv
// Shared sizing and state encoding for the IDCT stream sequencer.
package idct_ctrl_pkg;

   localparam int unsigned DATA_W  = 16;
   localparam int unsigned N       = 64;
   localparam int unsigned LATENCY = 29;
   localparam int unsigned CNT_W   = 7;
   localparam int unsigned IDX_W   = $clog2(N);
   localparam int unsigned BLK_W   = N * DATA_W;

   typedef enum logic [1:0] {
      LOAD,
      WAIT,
      DRAIN
   } state_e;

endpackage

// File: rtl/idct_blk_buf.sv
// N x DATA_W block register file: serial write port, parallel load, flattened read.
module idct_blk_buf
   import idct_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              ld_en,
   input  logic [BLK_W-1:0]  ld_data,
   output logic [BLK_W-1:0]  rd_data
);

   logic [DATA_W-1:0] mem_q [N];

   // Parallel load wins over a serial write in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < N; k++) mem_q[k] <= '0;
      end else if (ld_en) begin
         for (int unsigned k = 0; k < N; k++) mem_q[k] <= ld_data[k*DATA_W +: DATA_W];
      end else if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   // Flatten the storage onto the block bus, sample k at bits [k*DATA_W +: DATA_W].
   always_comb begin
      rd_data = '0;
      for (int unsigned k = 0; k < N; k++) rd_data[k*DATA_W +: DATA_W] = mem_q[k];
   end

endmodule

// File: rtl/idct_stream_ctrl.sv
// Serial-in / serial-out sequencer around a valid-less, fully pipelined IDCT core.
module idct_stream_ctrl
   import idct_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [BLK_W-1:0]  core_x,
   input  logic [BLK_W-1:0]  core_out,
   output logic              busy
);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic              busy_q;
   logic [DATA_W-1:0] out_data_q;
   logic [BLK_W-1:0]  core_x_q;

   logic [BLK_W-1:0]  ibuf_rd;
   logic [BLK_W-1:0]  obuf_rd;
   logic [BLK_W-1:0]  blk_full;
   logic [DATA_W-1:0] nxt_word;
   logic [CNT_W-1:0]  cnt_inc;
   logic              accept;
   logic              capture;

   assign cnt_inc = cnt_q + CNT_W'(1);
   assign accept  = in_valid && in_ready_q;
   assign capture = (state_q == WAIT) && (cnt_q == CNT_W'(LATENCY));

   idct_blk_buf u_ibuf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (accept),
      .wr_idx  (cnt_q[IDX_W-1:0]),
      .wr_data (in_data),
      .ld_en   (1'b0),
      .ld_data ('0),
      .rd_data (ibuf_rd)
   );

   idct_blk_buf u_obuf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (1'b0),
      .wr_idx  ('0),
      .wr_data ('0),
      .ld_en   (capture),
      .ld_data (core_out),
      .rd_data (obuf_rd)
   );

   // Block as it will look once the final word lands, so core_x updates on the same edge.
   always_comb begin
      blk_full = ibuf_rd;
      blk_full[(N-1)*DATA_W +: DATA_W] = in_data;
   end

   // Output-buffer word the drain advances to on a handshake.
   always_comb begin
      nxt_word = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (cnt_inc == CNT_W'(k)) nxt_word = obuf_rd[k*DATA_W +: DATA_W];
      end
   end

   // Sequencer: load a block, hold it for the core latency, then drain results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= LOAD;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         core_x_q    <= '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (accept) begin
                  busy_q <= 1'b1;
                  if (cnt_q == CNT_W'(N-1)) begin
                     core_x_q   <= blk_full;
                     cnt_q      <= '0;
                     in_ready_q <= 1'b0;
                     state_q    <= WAIT;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
            end
            WAIT: begin
               if (capture) begin
                  cnt_q       <= '0;
                  out_valid_q <= 1'b1;
                  out_data_q  <= core_out[DATA_W-1:0];
                  out_last_q  <= (N == 1);
                  state_q     <= DRAIN;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (cnt_q == CNT_W'(N-1)) begin
                     cnt_q       <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     in_ready_q  <= 1'b1;
                     busy_q      <= 1'b0;
                     state_q     <= LOAD;
                  end else begin
                     cnt_q      <= cnt_inc;
                     out_data_q <= nxt_word;
                     out_last_q <= (cnt_inc == CNT_W'(N-1));
                  end
               end
            end
            default: begin
               state_q <= LOAD;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign core_x    = core_x_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_idct_stream_ctrl.sv
// Directed bench for idct_stream_ctrl with a stand-in pipelined core.
module tb_idct_stream_ctrl;
   import idct_ctrl_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic [BLK_W-1:0]  core_x;
   logic [BLK_W-1:0]  core_out;
   logic              busy;

   int tests = 0;
   int fails = 0;

   logic [DATA_W-1:0] gold    [N];
   logic [DATA_W-1:0] cur_blk [N];
   int gold_vals [N] = '{
      -240,   8, -11,  47,   3,  -2,   0,   1,
        12,  -5,   7,   0,  -1,   2,   0,   0,
        -9,   4,   0,   3,   0,  -1,   0,   0,
         6,   0,  -2,   0,   1,   0,   0,   0,
        -3,   1,   0,   0,   0,   0,   0,   0,
         2,   0,   0,  -1,   0,   0,   0,   0,
         0,   0,   1,   0,   0,   0,   0,   0,
     32767, -32768, 0,  0,   0,   0,   0,  -8
   };

   always #5 clk = ~clk;

   idct_stream_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .core_x    (core_x),
      .core_out  (core_out),
      .busy      (busy)
   );

   // Stand-in core: reverses sample order, LATENCY register stages, no reset or valid.
   logic [BLK_W-1:0] pipe_q [LATENCY];

   function automatic logic [BLK_W-1:0] core_f(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) r[k*DATA_W +: DATA_W] = x[(N-1-k)*DATA_W +: DATA_W];
      return r;
   endfunction

   always @(posedge clk) begin
      pipe_q[0] <= core_f(core_x);
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
   end

   assign core_out = pipe_q[LATENCY-1];

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp_v);
      tests++;
      assert (obs === exp_v)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [BLK_W-1:0] pack_cur();
      logic [BLK_W-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) r[k*DATA_W +: DATA_W] = cur_blk[k];
      return r;
   endfunction

   // Stream cur_blk in; optional bubble every third cycle; optional junk afterwards.
   task automatic send_block(input bit bubble, input bit junk);
      int k;
      int cyc;
      k = 0;
      cyc = 0;
      while (k < N && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         chk("in_ready_load", 16'(in_ready), 16'd1);
         if (bubble && (cyc % 3 == 0)) begin
            in_valid = 1'b0;
            in_data  = 16'h7FFF;
         end else begin
            in_valid = 1'b1;
            in_data  = cur_blk[k];
            k++;
         end
      end
      chk("send_done", 16'(k), 16'(N));
      @(negedge clk);
      in_valid = junk;
      in_data  = 16'h7FFF;
      chk("core_x_block", 16'(core_x === pack_cur()), 16'd1);
      chk("busy_wait", 16'(busy), 16'd1);
      chk("in_ready_wait", 16'(in_ready), 16'd0);
   endtask

   // Collect one block; call right after send_block (one negedge after the last accept).
   task automatic recv_block(input bit bp, input bit junk);
      int wcnt;
      int idx;
      int cyc;
      bit have_prev;
      logic [DATA_W-1:0] prev_data;
      logic prev_last;
      logic rdy;
      wcnt = 0;
      while (out_valid !== 1'b1 && wcnt < 200) begin
         chk("in_ready_hold", 16'(in_ready), 16'd0);
         @(negedge clk);
         wcnt++;
         in_valid = junk;
         in_data  = 16'h7FFF;
      end
      chk("first_valid_latency", 16'(wcnt), 16'(LATENCY + 1));
      idx = 0;
      cyc = 0;
      have_prev = 1'b0;
      prev_data = '0;
      prev_last = 1'b0;
      while (idx < N && cyc < 1000) begin
         chk("out_valid_drain", 16'(out_valid), 16'd1);
         chk("in_ready_drain", 16'(in_ready), 16'd0);
         if (have_prev) begin
            chk("hold_data", out_data, prev_data);
            chk("hold_last", 16'(out_last), 16'(prev_last));
         end
         rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         out_ready = rdy;
         if (rdy) begin
            chk("out_data", out_data, cur_blk[N-1-idx]);
            chk("out_last", 16'(out_last), 16'(idx == N-1));
            idx++;
            have_prev = 1'b0;
         end else begin
            have_prev = 1'b1;
            prev_data = out_data;
            prev_last = out_last;
         end
         in_valid = junk;
         in_data  = 16'h7FFF;
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("drain_count", 16'(idx), 16'(N));
      chk("out_valid_after", 16'(out_valid), 16'd0);
      chk("out_last_after", 16'(out_last), 16'd0);
      chk("in_ready_after", 16'(in_ready), 16'd1);
      chk("busy_after", 16'(busy), 16'd0);
   endtask

   initial begin
      bit saw_valid;
      for (int i = 0; i < N; i++) gold[i] = 16'(gold_vals[i]);
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #2;
      chk("rst_in_ready", 16'(in_ready), 16'd1);
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_out_last", 16'(out_last), 16'd0);
      chk("rst_out_data", out_data, 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_core_x", 16'(core_x === '0), 16'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Golden block, no backpressure; out_ready also held high through LOAD and WAIT.
      for (int i = 0; i < N; i++) cur_blk[i] = gold[i];
      send_block(1'b0, 1'b0);
      recv_block(1'b0, 1'b0);

      // Backpressure 1,0,0,1 with 7FFF junk offered during WAIT and DRAIN.
      send_block(1'b0, 1'b1);
      recv_block(1'b1, 1'b1);

      // Input bubbles; also shows the junk above was never accepted.
      send_block(1'b1, 1'b0);
      recv_block(1'b0, 1'b0);

      // Reset ten cycles into WAIT: immediate, asynchronous return to idle.
      send_block(1'b0, 1'b0);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 16'(out_valid), 16'd0);
      chk("mid_rst_in_ready", 16'(in_ready), 16'd1);
      chk("mid_rst_busy", 16'(busy), 16'd0);
      chk("mid_rst_core_x", 16'(core_x === '0), 16'd1);
      @(negedge clk);
      rst = 1'b0;
      saw_valid = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid !== 1'b0) saw_valid = 1'b1;
      end
      chk("no_valid_after_rst", 16'(saw_valid), 16'd0);
      for (int i = 0; i < N; i++) cur_blk[i] = '0;
      send_block(1'b0, 1'b0);
      recv_block(1'b0, 1'b0);

      // Back-to-back: golden block followed immediately by an all-zero block.
      for (int i = 0; i < N; i++) cur_blk[i] = gold[i];
      send_block(1'b0, 1'b0);
      recv_block(1'b0, 1'b0);
      for (int i = 0; i < N; i++) cur_blk[i] = '0;
      send_block(1'b0, 1'b0);
      recv_block(1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
